// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: serial MAC over a circular delay line, round + saturate.
// Optional sticky out_sat flag with CIC_COMP_SAT_FLAG_EN.
module cic_comp_fir #(
    parameter int TAPS       = 15,
    parameter int IN_WIDTH   = 16,
    parameter int COEF_WIDTH = 18,
    parameter int COEF_FRAC  = 17,
    parameter int OUT_WIDTH  = 16,
    parameter logic [TAPS*COEF_WIDTH-1:0] COEFFS =
        (TAPS*COEF_WIDTH)'((1 << 17) - 1) << ((TAPS / 2) * COEF_WIDTH),
    parameter int USE_ROUND  = 1,
    parameter int USE_SAT    = 1
) (
    input  logic                 in_clock,
    input  logic                 in_reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data
`ifdef CIC_COMP_SAT_FLAG_EN
    ,
    output logic                 out_sat
`endif
);

    localparam int PW    = $clog2(TAPS);
    localparam int KW    = $clog2(TAPS + 1);
    localparam int MW    = IN_WIDTH + COEF_WIDTH;
    localparam int ACC_W = MW + $clog2(TAPS);

    typedef enum logic [1:0] {IDLE, MAC, FINAL, OUT} state_t;

    state_t state, state_nx;

    logic signed [IN_WIDTH-1:0]   dline [TAPS];
    logic        [PW-1:0]         wptr, base, tap, ridx;
    logic        [PW:0]           diff;
    logic        [KW-1:0]         k;
    logic signed [COEF_WIDTH-1:0] coef;
    logic signed [IN_WIDTH-1:0]   samp;
    logic signed [MW-1:0]         mul, prod;
    logic signed [ACC_W-1:0]      acc, half, rsum, shv;
    logic        [ACC_W-OUT_WIDTH:0] top;
    logic                         ovf, accept;
    logic        [OUT_WIDTH-1:0]  res;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MAC;
            MAC:     if (k == KW'(TAPS)) state_nx = FINAL;
            FINAL:   state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Tap k reads the sample written k accepts ago: (base - k) mod TAPS.
    always_comb begin
        tap  = (k < KW'(TAPS)) ? PW'(k) : '0;
        diff = {1'b0, base} + (PW+1)'(TAPS) - {1'b0, tap};
        if (diff >= (PW+1)'(TAPS)) ridx = PW'(diff - (PW+1)'(TAPS));
        else                       ridx = PW'(diff);
    end

    assign coef = COEFFS[int'(tap)*COEF_WIDTH +: COEF_WIDTH];
    assign samp = dline[ridx];
    assign mul  = MW'(coef) * MW'(samp);

    always_comb begin
        half = '0;
        if (USE_ROUND != 0) half = ACC_W'(1) << (COEF_FRAC - 1);
        rsum = acc + half;
        shv  = rsum >>> COEF_FRAC;
        top  = shv[ACC_W-1:OUT_WIDTH-1];
        ovf  = !((&top) || !(|top));
        res  = shv[OUT_WIDTH-1:0];
        if (USE_SAT != 0 && ovf)
            res = shv[ACC_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                               : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end

    // Multiplier output is registered; MAC runs one extra cycle to drain it.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            for (int i = 0; i < TAPS; i++) dline[i] <= '0;
            wptr      <= '0;
            base      <= '0;
            k         <= '0;
            prod      <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef CIC_COMP_SAT_FLAG_EN
            out_sat   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    dline[wptr] <= in_data;
                    base        <= wptr;
                    wptr        <= (wptr == PW'(TAPS - 1)) ? '0 : wptr + 1'b1;
                    acc         <= '0;
                    k           <= '0;
                end
                MAC: begin
                    prod <= mul;
                    if (k != '0)
                        acc <= acc + {{(ACC_W-MW){prod[MW-1]}}, prod};
                    k <= k + 1'b1;
                end
                FINAL: begin
                    out_data  <= res;
                    out_valid <= 1'b1;
`ifdef CIC_COMP_SAT_FLAG_EN
                    if (ovf) out_sat <= 1'b1;
`endif
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir (TAPS=4): impulse, DC/wrap, saturation,
// rounding, backpressure and reset mid-MAC.
module tb_cic_comp_fir;

    localparam logic [71:0] C_A  = {18'd0, 18'd16384, 18'h38000, 18'd65536};
    localparam logic [71:0] C_S  = {18'd0, 18'd0, 18'd131071, 18'd131071};
    localparam logic [71:0] C_R  = {18'd0, 18'd0, 18'd0, 18'd65536};

    logic clk = 1'b0;
    logic in_reset, in_valid, out_ready;
    logic [15:0] in_data;

    logic rdy_a, rdy_s, rdy_r0, rdy_r1;
    logic vld_a, vld_s, vld_r0, vld_r1;
    logic signed [15:0] d_a, d_s, d_r0, d_r1;
    logic signed [15:0] y_a, y_s, y_r0, y_r1;
`ifdef CIC_COMP_SAT_FLAG_EN
    logic sat_a, sat_s, sat_r0, sat_r1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int nxf   = 0;

    always #5 clk = ~clk;

    cic_comp_fir #(.TAPS(4), .COEFFS(C_A)) u_a (
        .in_clock(clk), .in_reset(in_reset), .in_valid(in_valid),
        .in_ready(rdy_a), .in_data(in_data), .out_valid(vld_a),
        .out_ready(out_ready), .out_data(d_a)
`ifdef CIC_COMP_SAT_FLAG_EN
        , .out_sat(sat_a)
`endif
    );

    cic_comp_fir #(.TAPS(4), .COEFFS(C_S)) u_s (
        .in_clock(clk), .in_reset(in_reset), .in_valid(in_valid),
        .in_ready(rdy_s), .in_data(in_data), .out_valid(vld_s),
        .out_ready(out_ready), .out_data(d_s)
`ifdef CIC_COMP_SAT_FLAG_EN
        , .out_sat(sat_s)
`endif
    );

    cic_comp_fir #(.TAPS(4), .COEFFS(C_R), .USE_ROUND(0)) u_r0 (
        .in_clock(clk), .in_reset(in_reset), .in_valid(in_valid),
        .in_ready(rdy_r0), .in_data(in_data), .out_valid(vld_r0),
        .out_ready(out_ready), .out_data(d_r0)
`ifdef CIC_COMP_SAT_FLAG_EN
        , .out_sat(sat_r0)
`endif
    );

    cic_comp_fir #(.TAPS(4), .COEFFS(C_R), .USE_ROUND(1)) u_r1 (
        .in_clock(clk), .in_reset(in_reset), .in_valid(in_valid),
        .in_ready(rdy_r1), .in_data(in_data), .out_valid(vld_r1),
        .out_ready(out_ready), .out_data(d_r1)
`ifdef CIC_COMP_SAT_FLAG_EN
        , .out_sat(sat_r1)
`endif
    );

    always @(posedge clk) if (vld_a && out_ready) nxf++;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        in_reset = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
    endtask

    // Handshake one sample, then wait for out_valid and capture all outputs.
    task automatic xfer(input logic [15:0] d, input bit chk_lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_a) chk("rdy_timeout", rdy_a, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'h5a5a;
        n = 0;
        while (!vld_a && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid", vld_a, 1);
        if (chk_lat) chk("latency", n, 6);
        y_a  = d_a;
        y_s  = d_s;
        y_r0 = d_r0;
        y_r1 = d_r1;
    endtask

    initial begin
        int exp_imp[6] = '{500, -250, 125, 0, 0, 0};
        int nxf0;
        bit ok;
        in_reset  = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", vld_a, 0);
        chk("rst_data", d_a, 0);
        chk("rst_ready", rdy_a, 1);
        chk("rst_ready_s", rdy_s, 1);
`ifdef CIC_COMP_SAT_FLAG_EN
        chk("rst_sat", sat_s, 0);
`endif
        @(negedge clk);
        in_reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            xfer((i == 0) ? 16'd1000 : 16'd0, 1'b1);
            chk("impulse", y_a, exp_imp[i]);
        end

        rst_pulse();
        for (int i = 0; i < 12; i++) begin
            xfer(16'd1000, 1'b0);
            chk("dc_wrap", y_a, (i == 0) ? 500 : (i == 1) ? 250 : 375);
        end

        rst_pulse();
        xfer(16'sd32767, 1'b0);
        chk("sat_pos0", y_s, 32767);
        xfer(16'sd32767, 1'b0);
        chk("sat_pos1", y_s, 32767);
        rst_pulse();
        xfer(16'h8000, 1'b0);
        chk("sat_neg0", y_s, -32768);
        xfer(16'h8000, 1'b0);
        chk("sat_neg1", y_s, -32768);
`ifdef CIC_COMP_SAT_FLAG_EN
        chk("sat_flag", sat_s, 1);
        chk("sat_flag_a", sat_a, 0);
`endif

        rst_pulse();
        xfer(16'sd3, 1'b0);
        chk("round_p3", y_r1, 2);
        chk("trunc_p3", y_r0, 1);
        xfer(-16'sd3, 1'b0);
        chk("round_m3", y_r1, -1);
        chk("trunc_m3", y_r0, -2);

        rst_pulse();
        out_ready = 1'b0;
        xfer(16'd1000, 1'b1);
        chk("bp_data", y_a, 500);
        nxf0 = nxf;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!vld_a || rdy_a || d_a !== 16'sd500) ok = 1'b0;
        end
        chk("bp_hold", ok, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drop", vld_a, 0);
        chk("bp_ready", rdy_a, 1);
        @(posedge clk);
        #1;
        chk("bp_one_xfer", nxf - nxf0, 1);

        rst_pulse();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        #1;
        chk("midmac_valid", vld_a, 0);
        chk("midmac_ready", rdy_a, 1);
        @(negedge clk);
        in_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xfer((i == 0) ? 16'd1000 : 16'd0, 1'b1);
            chk("post_rst", y_a, exp_imp[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
